// File: rtl/rf_param.sv
// rf_param -- parametrised general register file with flags and bus drive.
//
// Purpose:
//   NREGS registers of WIDTH bits, one write port that can load, increment
//   or decrement in place, two combinational read ports with write bypass,
//   a set/clear-maskable flags register, and a registered bus output that
//   can drive any register or the flags.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   we/wop/waddr/wdata   write port (wop: 00 load, 01 inc, 10 dec, 11 load)
//   ra/qa, rb/qb   read ports, zero latency, bypass from the write port
//   fi/fset/fclr/fd/fq   flags load enable, set mask, clear mask, load data, value
//   oe/osel        bus enable and source (osel MSB selects flags)
//   p/pv           registered bus data and valid
//   wrap           one-cycle pulse after an inc/dec that wrapped around
module rf_param #(
    parameter int WIDTH   = 8,
    parameter int NREGS   = 4,
    parameter int AW      = $clog2(NREGS),
    parameter int FW      = 8,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       wop,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    output logic [WIDTH-1:0] qa,
    output logic [WIDTH-1:0] qb,
    input  logic             fi,
    input  logic [FW-1:0]    fset,
    input  logic [FW-1:0]    fclr,
    input  logic [FW-1:0]    fd,
    output logic [FW-1:0]    fq,
    input  logic             oe,
    input  logic [AW:0]      osel,
    output logic [WIDTH-1:0] p,
    output logic             pv,
    output logic             wrap
);

    localparam logic Z0 = (ZERO_R0 != 0);

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] res;
    logic             wr_en;
    logic             wrap_nxt;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic [WIDTH-1:0] rd_o;
    logic [WIDTH-1:0] fext;
    logic [WIDTH-1:0] bus_src;
    logic [FW-1:0]    fq_nxt;

    assign cur = regs[waddr];

    // Post-op value of the write port; also what the bypass presents.
    always_comb begin
        res = wdata;
        case (wop)
            2'b01:   res = cur + WIDTH'(1);
            2'b10:   res = cur - WIDTH'(1);
            default: res = wdata;
        endcase
    end

    // With ZERO_R0, r0 is never written, never wraps, never bypasses.
    assign wr_en = we && !(Z0 && (waddr == '0));

    assign wrap_nxt = wr_en && (((wop == 2'b01) && (res == '0)) ||
                                ((wop == 2'b10) && (res == '1)));

    // Stored reads, with r0 forced to zero when it is hardwired.
    assign rd_a = (Z0 && (ra == '0)) ? '0 : regs[ra];
    assign rd_b = (Z0 && (rb == '0)) ? '0 : regs[rb];
    assign rd_o = (Z0 && (osel[AW-1:0] == '0)) ? '0 : regs[osel[AW-1:0]];

    assign qa = (wr_en && (waddr == ra)) ? res : rd_a;
    assign qb = (wr_en && (waddr == rb)) ? res : rd_b;

    generate
        if (FW >= WIDTH) begin : g_ftrunc
            assign fext = fq[WIDTH-1:0];
        end else begin : g_fzext
            assign fext = {{(WIDTH-FW){1'b0}}, fq};
        end
    endgenerate

    // Bus samples the pre-update value; a same-cycle write shows on the next oe.
    assign bus_src = osel[AW] ? fext : rd_o;

    // Clear is applied last so it wins over set.
    assign fq_nxt = ((fi ? fd : fq) | fset) & ~fclr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            fq   <= '0;
            p    <= '0;
            pv   <= 1'b0;
            wrap <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[waddr] <= res;
            end
            wrap <= wrap_nxt;
            fq   <= fq_nxt;
            p    <= oe ? bus_src : '0;
            pv   <= oe;
        end
    end

endmodule

// File: tb/tb_rf_param.sv
module tb_rf_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus (full-width); each DUT sees the low bits it needs.
    logic        we = 0;
    logic [1:0]  wop = 0;
    logic [2:0]  waddr = 0, ra = 0, rb = 0, oidx = 0;
    logic [15:0] wdata = 0;
    logic        fi = 0, oe = 0, osf = 0;
    logic [7:0]  fset = 0, fclr = 0, fd = 0;

    // DUT 0: defaults. DUT 1: WIDTH=16, NREGS=8, ZERO_R0=1.
    logic [7:0]  qa0, qb0, p0, fq0;
    logic        pv0, wrap0;
    logic [15:0] qa1, qb1, p1;
    logic [7:0]  fq1;
    logic        pv1, wrap1;

    rf_param u0 (
        .clk(clk), .rst(rst), .we(we), .wop(wop), .waddr(waddr[1:0]),
        .wdata(wdata[7:0]), .ra(ra[1:0]), .rb(rb[1:0]), .qa(qa0), .qb(qb0),
        .fi(fi), .fset(fset), .fclr(fclr), .fd(fd), .fq(fq0),
        .oe(oe), .osel({osf, oidx[1:0]}), .p(p0), .pv(pv0), .wrap(wrap0)
    );

    rf_param #(.WIDTH(16), .NREGS(8), .ZERO_R0(1)) u1 (
        .clk(clk), .rst(rst), .we(we), .wop(wop), .waddr(waddr),
        .wdata(wdata), .ra(ra), .rb(rb), .qa(qa1), .qb(qb1),
        .fi(fi), .fset(fset), .fclr(fclr), .fd(fd), .fq(fq1),
        .oe(oe), .osel({osf, oidx}), .p(p1), .pv(pv1), .wrap(wrap1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Reference model: plain modular arithmetic over an array per DUT.
    int unsigned mw [2] = '{8, 16};
    int unsigned mn [2] = '{4, 8};
    bit          mz [2] = '{1'b0, 1'b1};
    int unsigned mreg [2][8];
    int unsigned mfq  [2];

    typedef struct {
        int unsigned p0, p1, fq0, fq1;
        bit pv0, pv1, w0, w1;
    } exp_t;
    exp_t sb[$];

    function automatic int unsigned modw(int d);
        return 1 << mw[d];
    endfunction

    function automatic int unsigned mread(int d, int unsigned a);
        if (mz[d] && a == 0) return 0;
        return mreg[d][a];
    endfunction

    task automatic mreset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) mreg[d][i] = 0;
            mfq[d] = 0;
        end
    endtask

    task automatic step(input bit s_we, input int s_wop, input int s_wa, input int unsigned s_wd,
                        input int s_ra, input int s_rb, input bit s_fi, input int s_fs,
                        input int s_fc, input int s_fd, input bit s_oe, input bit s_osf,
                        input int s_oi);
        int unsigned wa, a, b, oi, old, res, eqa, eqb, ep;
        bit wen, ew;
        int unsigned efq;
        exp_t e;
        @(negedge clk);
        we = s_we; wop = 2'(s_wop); waddr = 3'(s_wa); wdata = 16'(s_wd);
        ra = 3'(s_ra); rb = 3'(s_rb); fi = s_fi; fset = 8'(s_fs); fclr = 8'(s_fc);
        fd = 8'(s_fd); oe = s_oe; osf = s_osf; oidx = 3'(s_oi);
        #1;
        for (int d = 0; d < 2; d++) begin
            wa = s_wa % mn[d]; a = s_ra % mn[d]; b = s_rb % mn[d]; oi = s_oi % mn[d];
            old = mread(d, wa);
            if (s_wop == 1)      res = (old + 1) % modw(d);
            else if (s_wop == 2) res = (old + modw(d) - 1) % modw(d);
            else                 res = s_wd % modw(d);
            wen = s_we && !(mz[d] && wa == 0);
            eqa = (wen && wa == a) ? res : mread(d, a);
            eqb = (wen && wa == b) ? res : mread(d, b);
            chk("qa", d, (d == 0) ? {24'h0, qa0} : {16'h0, qa1}, eqa);
            chk("qb", d, (d == 0) ? {24'h0, qb0} : {16'h0, qb1}, eqb);
            ep = !s_oe ? 0 : (s_osf ? mfq[d] % modw(d) : mread(d, oi));
            ew = wen && ((s_wop == 1 && res == 0) || (s_wop == 2 && res == modw(d) - 1));
            efq = ((s_fi ? s_fd : mfq[d]) | s_fs) & ~s_fc & 8'hFF;
            if (wen) mreg[d][wa] = res;
            mfq[d] = efq;
            if (d == 0) begin e.p0 = ep; e.pv0 = s_oe; e.w0 = ew; e.fq0 = efq; end
            else        begin e.p1 = ep; e.pv1 = s_oe; e.w1 = ew; e.fq1 = efq; end
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int ra_, input int rb_);
        step(0, 0, 0, 0, ra_, rb_, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: registered outputs are presented once per edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst && sb.size() > 0) begin
            e = sb.pop_front();
            chk("p",    0, {24'h0, p0},  e.p0);
            chk("pv",   0, {31'h0, pv0}, {31'h0, e.pv0});
            chk("wrap", 0, {31'h0, wrap0}, {31'h0, e.w0});
            chk("fq",   0, {24'h0, fq0}, e.fq0);
            chk("p",    1, {16'h0, p1},  e.p1);
            chk("pv",   1, {31'h0, pv1}, {31'h0, e.pv1});
            chk("wrap", 1, {31'h0, wrap1}, {31'h0, e.w1});
            chk("fq",   1, {24'h0, fq1}, e.fq1);
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_qa"}, 0, {24'h0, qa0}, 0);
        chk({tag, "_qb"}, 0, {24'h0, qb0}, 0);
        chk({tag, "_fq"}, 0, {24'h0, fq0}, 0);
        chk({tag, "_p"},  0, {24'h0, p0},  0);
        chk({tag, "_pv"}, 0, {31'h0, pv0}, 0);
        chk({tag, "_wrap"}, 0, {31'h0, wrap0}, 0);
        chk({tag, "_qa"}, 1, {16'h0, qa1}, 0);
        chk({tag, "_fq"}, 1, {24'h0, fq1}, 0);
        chk({tag, "_p"},  1, {16'h0, p1},  0);
        chk({tag, "_pv"}, 1, {31'h0, pv1}, 0);
    endtask

    initial begin
        mreset();
        ra = 3'd1; rb = 3'd2;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Load with bypass, then stored read.
        step(1, 0, 1, 100, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("bypass_const", 0, {24'h0, qa0}, 100);
        idle(0, 1);
        chk("stored_const", 0, {24'h0, qb0}, 100);

        // Inc/dec wrap on r2, then a load clears wrap.
        step(1, 0, 2, 16'hFFFF, 2, 2, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 2, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0);
        step(1, 2, 2, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 2, 5, 2, 2, 0, 0, 0, 0, 0, 0, 0);
        idle(2, 2);

        // Flags: load, set/clear, clear-wins.
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h04, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 8'h81, 8'h01, 0, 0, 0, 0);
        idle(0, 0);
        chk("fq_const", 0, {24'h0, fq0}, 8'h84);
        step(0, 0, 0, 0, 0, 0, 1, 0, 8'hFF, 8'hFF, 0, 0, 0);

        // Bus: register, flags, off, same-cycle write then re-read.
        step(1, 0, 3, 64, 3, 3, 1, 0, 0, 8'h84, 0, 0, 0);
        step(0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 1, 0, 3);
        step(0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 3, 4, 3, 3, 0, 0, 0, 0, 1, 0, 3);
        step(0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 1, 0, 3);

        // r0 write (ignored on DUT1), r7 wrap (r3 on DUT0).
        step(1, 0, 0, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("r0_zero", 1, {16'h0, qa1}, 0);
        step(1, 0, 7, 16'hFFFF, 7, 7, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 7, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0);
        idle(7, 7);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            int unsigned wdv;
            wdv = ($urandom_range(0, 3) == 0) ? 16'hFFFF : $urandom_range(0, 16'hFFFF);
            if ($urandom_range(0, 3) == 0) wdv = 0;
            step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7), wdv,
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 255) & $urandom_range(0, 255),
                 $urandom_range(0, 255) & $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 7));
        end

        // Async reset between edges, held across edges with writes pending.
        step(1, 0, 1, 77, 1, 1, 1, 0, 0, 8'h3C, 1, 0, 1);
        @(negedge clk);
        we = 0; oe = 0; fi = 0;
        #2;
        rst = 1'b0;
        #1;
        sb.delete();
        mreset();
        ra = 3'd1; rb = 3'd1;
        chk_all_zero("async_rst");
        we = 1; wop = 0; waddr = 3'd1; wdata = 16'h55; oe = 1; fi = 1; fd = 8'hAA;
        repeat (2) @(posedge clk);
        #1;
        we = 0;
        #1;
        chk_all_zero("held_rst");
        @(negedge clk);
        oe = 0; fi = 0; fd = 0;
        rst = 1'b1;
        idle(1, 1);
        step(1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1);
        idle(1, 1);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
